// File: rtl/e_mdu_iter.sv
// e_mdu_iter: E-stage multiply/divide unit owning HI/LO; fixed-latency multiply, iterative restoring divide.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 9-12) accumulating into {hi,lo}.
module e_mdu_iter #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             start,
   output logic             busy,
   output logic [WIDTH-1:0] mdu_out,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;
`endif
   localparam int CW = $clog2(WIDTH > MUL_LAT ? WIDTH : MUL_LAT) + 1;
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   quo, dvs, rem;
   logic               sgn_r, a_neg, b_neg;
   logic               is_mul, is_div, sgn_in, a_neg_in, b_neg_in;
   logic [WIDTH:0]     rem_sh, diff;
   logic [2*WIDTH-1:0] ea, eb, prod, acc;
   logic [WIDTH-1:0]   q_fix, r_fix;

`ifdef MDU_MADD_EN
   logic [1:0] mac_r;
   assign is_mul = op == OP_MULT || op == OP_MULTU || (op >= OP_MADD && op <= OP_MSUBU);
   assign sgn_in = op == OP_MULT || op == OP_DIV || op == OP_MADD || op == OP_MSUB;
`else
   assign is_mul = op == OP_MULT || op == OP_MULTU;
   assign sgn_in = op == OP_MULT || op == OP_DIV;
`endif
   assign is_div   = op == OP_DIV || op == OP_DIVU;
   assign start    = !busy && !req && (is_mul || is_div);
   assign mdu_out  = op == OP_MFHI ? hi : op == OP_MFLO ? lo : '0;
   // the divider works on magnitudes; only signed divides fold the operand signs away at capture
   assign a_neg_in = is_div && sgn_in && a[WIDTH-1];
   assign b_neg_in = is_div && sgn_in && b[WIDTH-1];

   // sign-extending both operands to 2*WIDTH makes the truncated product correct for signed and unsigned
   assign ea   = sgn_r ? {{WIDTH{quo[WIDTH-1]}}, quo} : {{WIDTH{1'b0}}, quo};
   assign eb   = sgn_r ? {{WIDTH{dvs[WIDTH-1]}}, dvs} : {{WIDTH{1'b0}}, dvs};
   assign prod = ea * eb;
`ifdef MDU_MADD_EN
   assign acc  = !mac_r[0] ? prod : mac_r[1] ? {hi, lo} - prod : {hi, lo} + prod;
`else
   assign acc  = prod;
`endif

   // one restoring step: a set top bit in diff means the trial subtraction went negative
   assign rem_sh = {rem, quo[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dvs};
   assign q_fix  = (a_neg ^ b_neg) ? -quo : quo;
   assign r_fix  = a_neg ? -rem : rem;

   // FSM, operand capture, divider iteration and HI/LO commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         quo   <= '0;
         dvs   <= '0;
         rem   <= '0;
         sgn_r <= 1'b0;
         a_neg <= 1'b0;
         b_neg <= 1'b0;
`ifdef MDU_MADD_EN
         mac_r <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               rem <= '0;
               if (start) begin
                  state <= is_div ? DIV : MUL;
                  busy  <= 1'b1;
                  sgn_r <= sgn_in;
                  a_neg <= a_neg_in;
                  b_neg <= b_neg_in;
                  quo   <= a_neg_in ? -a : a;
                  dvs   <= b_neg_in ? -b : b;
`ifdef MDU_MADD_EN
                  mac_r <= {op == OP_MSUB || op == OP_MSUBU, op >= OP_MADD};
`endif
               end else if (!req && op == OP_MTHI) begin
                  hi <= a;
               end else if (!req && op == OP_MTLO) begin
                  lo <= a;
               end
            end
            MUL: begin
               cnt <= cnt + 1'b1;
               if (cnt == MUL_LAST) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  {hi, lo} <= acc;
               end
            end
            DIV: begin
               cnt <= cnt + 1'b1;
               rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], !diff[WIDTH]};
               if (cnt == DIV_LAST) state <= FIX;
            end
            FIX: begin
               state <= IDLE;
               busy  <= 1'b0;
               hi    <= r_fix;
               lo    <= q_fix;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_e_mdu_iter.sv
// tb_e_mdu_iter: scoreboard bench for e_mdu_iter (WIDTH=32, MUL_LAT=5); MDU_MADD_EN selects the accumulate checks.
module tb_e_mdu_iter;
   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;

   logic        clk = 1'b0;
   logic        reset, req;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        start, busy;
   logic [31:0] mdu_out, hi, lo;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi, m_lo;

   e_mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
      .clk(clk), .reset(reset), .req(req), .op(op), .a(a), .b(b),
      .start(start), .busy(busy), .mdu_out(mdu_out), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      int sx, sy;
      logic [31:0] q, r;
      logic [63:0] ps, pu;
      sx = x;
      sy = y;
      ps = 64'(longint'(sx) * longint'(sy));
      pu = {32'h0, x} * {32'h0, y};
      q = '0;
      r = '0;
      if (o == OP_DIV) begin
         if (y == 0) begin
            q = x[31] ? 32'h1 : 32'hFFFF_FFFF;
            r = x;
         end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = x;
            r = '0;
         end else begin
            q = 32'(sx / sy);
            r = 32'(sx % sy);
         end
      end else if (o == OP_DIVU) begin
         q = (y == 0) ? 32'hFFFF_FFFF : x / y;
         r = (y == 0) ? x : x % y;
      end
      case (o)
         OP_MULT:  return ps;
         OP_MULTU: return pu;
         OP_DIV, OP_DIVU: return {r, q};
         OP_MADD:  return {m_hi, m_lo} + ps;
         OP_MADDU: return {m_hi, m_lo} + pu;
         OP_MSUB:  return {m_hi, m_lo} - ps;
         OP_MSUBU: return {m_hi, m_lo} - pu;
         default:  return {m_hi, m_lo};
      endcase
   endfunction

   task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output logic st, output int lat);
      @(negedge clk);
      op = o; a = x; b = y;
      #1 st = start;
      if (st) begin
         sb_q.push_back(model(o, x, y));
         {m_hi, m_lo} = sb_q[$];
      end
      @(posedge clk);
      #1;
      op = OP_NONE; a = $urandom; b = $urandom;
      lat = 0;
      while (busy === 1'b1 && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic do_mt(input logic [3:0] o, input logic [31:0] x);
      @(negedge clk);
      op = o; a = x;
      @(posedge clk);
      #1 op = OP_NONE;
      if (o == OP_MTHI) m_hi = x; else m_lo = x;
   endtask

   task automatic check_op(input string name, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int want_lat);
      logic st;
      int lat;
      logic [63:0] e;
      do_op(o, x, y, st, lat);
      n_chk++;
      if (st !== 1'b1) begin n_fail++; $display("FAIL %s_start op=%0d got %b want 1", name, o, st); end
      n_chk++;
      if (lat != want_lat) begin n_fail++; $display("FAIL %s_latency op=%0d got %0d want %0d", name, o, lat, want_lat); end
      e = sb_q.size() != 0 ? sb_q.pop_front() : 'x;
      n_chk++;
      if ({hi, lo} !== e) begin n_fail++; $display("FAIL %s_result op=%0d a=%h b=%h got %h want %h", name, o, x, y, {hi, lo}, e); end
   endtask

   task automatic test_reset;
      reset = 1'b1; req = 1'b0; op = OP_NONE; a = '0; b = '0;
      #1;
      n_chk++;
      if ({busy, start, hi, lo, mdu_out} !== '0) begin n_fail++; $display("FAIL reset_state got busy=%b start=%b hi=%h lo=%h out=%h want all 0", busy, start, hi, lo, mdu_out); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      do_mt(OP_MTHI, 32'hAAAA_0001);
      do_mt(OP_MTLO, 32'h5555_0002);
      @(negedge clk);
      op = OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
      @(posedge clk);
      #1 op = OP_NONE;
      repeat (9) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_chk++;
      if ({busy, hi, lo} !== '0) begin n_fail++; $display("FAIL reset_mid_div got busy=%b hi=%h lo=%h want 0", busy, hi, lo); end
      @(negedge clk);
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      sb_q.delete();
      check_op("reset_then_mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5);
   endtask

   task automatic test_mult;
      logic [31:0] xs[5] = '{32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h1234_5678};
      logic [31:0] ys[5] = '{32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h9ABC_DEF0};
      for (int i = 0; i < 5; i++) begin
         check_op("mult", OP_MULT, xs[i], ys[i], 5);
         check_op("multu", OP_MULTU, xs[i], ys[i], 5);
      end
      check_op("mult_rand", OP_MULT, $urandom, $urandom, 5);
      @(negedge clk);
      op = OP_MFHI;
      #1;
      n_chk++;
      if (mdu_out !== m_hi) begin n_fail++; $display("FAIL mfhi got %h want %h", mdu_out, m_hi); end
      op = OP_MTHI;
      #1;
      n_chk++;
      if (mdu_out !== 32'h0) begin n_fail++; $display("FAIL mdu_out_other got %h want 0", mdu_out); end
      op = OP_NONE;
   endtask

   task automatic test_div;
      logic [3:0]  os[7] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
      logic [31:0] xs[7] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd100, 32'h8765_4321};
      logic [31:0] ys[7] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFF9, 32'h0000_1234};
      for (int i = 0; i < 7; i++) check_op("div", os[i], xs[i], ys[i], 33);
      check_op("div_rand", OP_DIV, $urandom, $urandom_range(1, 32'hFFFF), 33);
      check_op("divu_rand", OP_DIVU, $urandom, $urandom, 33);
   endtask

   task automatic test_req;
      do_mt(OP_MTLO, 32'h0000_1234);
      @(negedge clk);
      req = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6;
      #1;
      n_chk++;
      if (start !== 1'b0) begin n_fail++; $display("FAIL req_start got %b want 0", start); end
      @(posedge clk);
      #1;
      n_chk++;
      if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin n_fail++; $display("FAIL req_squash got busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, m_hi, m_lo); end
      op = OP_MTLO; a = 32'd5;
      @(posedge clk);
      #1;
      n_chk++;
      if (lo !== m_lo) begin n_fail++; $display("FAIL req_mtlo got %h want %h", lo, m_lo); end
      @(negedge clk);
      req = 1'b0;
      @(posedge clk);
      #1;
      op = OP_NONE;
      n_chk++;
      if ({busy, lo} !== {1'b0, 32'd5}) begin n_fail++; $display("FAIL mtlo got busy=%b lo=%h want 0 00000005", busy, lo); end
      m_lo = 32'd5;
   endtask

   task automatic test_back_to_back;
      logic [31:0] old_lo;
      logic [63:0] e;
      int lat;
      old_lo = m_lo;
      @(negedge clk);
      op = OP_DIVU; a = 32'd100; b = 32'd7;
      #1;
      n_chk++;
      if (start !== 1'b1) begin n_fail++; $display("FAIL b2b_div_start got %b want 1", start); end
      sb_q.push_back(model(OP_DIVU, 32'd100, 32'd7));
      {m_hi, m_lo} = sb_q[$];
      @(posedge clk);
      #1;
      lat = 0;
      while (busy === 1'b1 && lat < 100) begin
         op = OP_MFLO;
         #1;
         n_chk++;
         if (mdu_out !== old_lo) begin n_fail++; $display("FAIL b2b_mflo cyc=%0d got %h want %h", lat, mdu_out, old_lo); end
         op = OP_MULT; a = 32'd3; b = 32'd4;
         #1;
         n_chk++;
         if (start !== 1'b0) begin n_fail++; $display("FAIL b2b_held_start cyc=%0d got %b want 0", lat, start); end
         @(posedge clk);
         #1 lat++;
      end
      n_chk++;
      if (lat != 33) begin n_fail++; $display("FAIL b2b_div_latency got %0d want 33", lat); end
      e = sb_q.size() != 0 ? sb_q.pop_front() : 'x;
      n_chk++;
      if ({hi, lo} !== e) begin n_fail++; $display("FAIL b2b_div_result got %h want %h", {hi, lo}, e); end
      n_chk++;
      if (start !== 1'b1) begin n_fail++; $display("FAIL b2b_mult_start got %b want 1", start); end
      sb_q.push_back(model(OP_MULT, 32'd3, 32'd4));
      {m_hi, m_lo} = sb_q[$];
      @(posedge clk);
      #1 op = OP_NONE;
      lat = 0;
      while (busy === 1'b1 && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      n_chk++;
      if (lat != 5) begin n_fail++; $display("FAIL b2b_mult_latency got %0d want 5", lat); end
      e = sb_q.size() != 0 ? sb_q.pop_front() : 'x;
      n_chk++;
      if ({hi, lo} !== e) begin n_fail++; $display("FAIL b2b_mult_result got %h want %h", {hi, lo}, e); end
   endtask

   task automatic test_madd;
`ifdef MDU_MADD_EN
      do_mt(OP_MTHI, 32'h0);
      do_mt(OP_MTLO, 32'hFFFF_FFFF);
      check_op("maddu", OP_MADDU, 32'd1, 32'd1, 5);
      n_chk++;
      if ({hi, lo} !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL maddu_carry got %h want 0000000100000000", {hi, lo}); end
      do_mt(OP_MTHI, 32'h0);
      do_mt(OP_MTLO, 32'h0);
      check_op("msub", OP_MSUB, 32'd1, 32'd1, 5);
      check_op("madd_rand", OP_MADD, $urandom, $urandom, 5);
      check_op("msubu_rand", OP_MSUBU, $urandom, $urandom, 5);
`else
      do_mt(OP_MTHI, 32'h0);
      do_mt(OP_MTLO, 32'hFFFF_FFFF);
      for (int o = 9; o <= 12; o++) begin
         @(negedge clk);
         op = 4'(o); a = 32'd1; b = 32'd1;
         #1;
         n_chk++;
         if (start !== 1'b0) begin n_fail++; $display("FAIL madd_disabled_start op=%0d got %b want 0", o, start); end
         @(posedge clk);
         #1;
         n_chk++;
         if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin n_fail++; $display("FAIL madd_disabled_state op=%0d got busy=%b hi=%h lo=%h", o, busy, hi, lo); end
      end
      op = OP_NONE;
`endif
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_req;
      test_back_to_back;
      test_madd;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end
endmodule
